// File: rtl/point_renderer_pkg.sv
// Purpose: shared types for the point renderer: FSM states, pixel modes, point word layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package point_renderer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Pixel/clip modes
   localparam logic [1:0] MODE_GRAY   = 2'd0;  // pixel = z[9:2], clipped points dropped
   localparam logic [1:0] MODE_INVERT = 2'd1;  // pixel = ~z[9:2], clipped points dropped
   localparam logic [1:0] MODE_WHITE  = 2'd2;  // pixel = 8'hFF, clipped points dropped
   localparam logic [1:0] MODE_CLAMP  = 2'd3;  // pixel = z[9:2], clipped points saturated

   localparam int PT_WORD_W = 36;

   // Memory word layout: {rsvd[35:30], x[29:20], y[19:10], z[9:0]}
   typedef struct packed {
      logic [5:0] rsvd;
      logic [9:0] x;
      logic [9:0] y;
      logic [9:0] z;
   } pt_word_t;

endpackage

// File: rtl/point_fifo.sv
// Purpose: synchronous FIFO with occupancy count; head word is visible combinationally.
// Latency: a word pushed on one edge is readable at pop_data after that edge.
// Backpressure: push ignored when full, pop ignored when empty; count lets the caller reserve space.
// Ports: clk, reset (sync, active-high); push/push_data; pop/pop_data; count, empty, full.
module point_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               pop_data,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           empty,
   output logic                           full
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/point_renderer.sv
// Purpose: fetch a frame of packed points from ZBT memory, pan/clip them and emit pixels in address order.
// Latency: first point reaches pt_valid ZBT_LATENCY+2 cycles after the accepted start.
// Backpressure: pt_ready stalls the output register; reads are only issued when the FIFO can absorb them.
// Ports: clk, reset (sync, active-high); start/base_addr/num_points/camera_offset/mode frame setup;
//        zbt0_read_addr/zbt0_read_data memory port; pt_valid/pt_ready/x/y/pixel point stream; busy, done.
module point_renderer
   import point_renderer_pkg::*;
#(
   parameter int NUM_POINTS_W = 19,
   parameter int ZBT_LATENCY  = 2,
   parameter int X_LIMIT      = 1024,
   parameter int Y_LIMIT      = 768,
   parameter int OFFSET_SHIFT = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [18:0]             base_addr,
   input  logic [NUM_POINTS_W-1:0] num_points,
   input  logic [5:0]              camera_offset,
   input  logic [1:0]              mode,
   input  logic [35:0]             zbt0_read_data,
   output logic [18:0]             zbt0_read_addr,
   output logic                    pt_valid,
   input  logic                    pt_ready,
   output logic [9:0]              x,
   output logic [9:0]              y,
   output logic [7:0]              pixel,
   output logic                    busy,
   output logic                    done
);

   localparam int FIFO_DEPTH = ZBT_LATENCY + 2;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W      = CNT_W + 1;

   localparam logic [10:0] X_LIM = 11'(X_LIMIT);
   localparam logic [10:0] Y_LIM = 11'(Y_LIMIT);
   localparam logic [9:0]  X_MAX = 10'(X_LIMIT - 1);
   localparam logic [9:0]  Y_MAX = 10'(Y_LIMIT - 1);

   state_t                  state;
   state_t                  state_nxt;

   logic [NUM_POINTS_W-1:0] num_q;
   logic [NUM_POINTS_W-1:0] issue_cnt;
   logic [5:0]              offset_q;
   logic [1:0]              mode_q;

   // Bit i set means a read issued i+1 cycles ago is still in flight.
   logic [ZBT_LATENCY-1:0]  rd_vld_sr;
   logic [OCC_W-1:0]        rd_outstanding;

   logic                    start_ok;
   logic                    issue_fire;
   logic                    last_issue;

   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_empty;
   logic [CNT_W-1:0]        fifo_count;
   pt_word_t                fifo_dat;
   logic                    unused_fifo_full;
   logic                    unused_bits;

   logic [10:0]             x_sum;
   logic                    x_clip;
   logic                    y_clip;
   logic                    pt_keep;
   logic [9:0]              x_nxt;
   logic [9:0]              y_nxt;
   logic [7:0]              pix_nxt;
   logic                    out_free;

   assign start_ok   = (state == ST_IDLE) && start;
   assign last_issue = (issue_cnt == (num_q - NUM_POINTS_W'(1)));

   always_comb begin
      rd_outstanding = '0;
      for (int i = 0; i < ZBT_LATENCY; i++) begin
         rd_outstanding = rd_outstanding + OCC_W'(rd_vld_sr[i]);
      end
   end

   // In-flight reads plus buffered words never exceed the FIFO depth, so
   // every returning word has a slot regardless of pt_ready.
   assign issue_fire = (state == ST_ISSUE) &&
                       ((rd_outstanding + OCC_W'(fifo_count)) < OCC_W'(FIFO_DEPTH));

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = (num_points == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            busy = 1'b1;
            if (issue_fire && last_issue) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if ((rd_vld_sr == '0) && fifo_empty && !pt_valid) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- frame setup and read issue ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         num_q          <= '0;
         offset_q       <= '0;
         mode_q         <= '0;
         issue_cnt      <= '0;
         zbt0_read_addr <= '0;
         rd_vld_sr      <= '0;
      end else begin
         rd_vld_sr[0] <= issue_fire;
         for (int i = 1; i < ZBT_LATENCY; i++) begin
            rd_vld_sr[i] <= rd_vld_sr[i-1];
         end
         if (start_ok) begin
            num_q     <= num_points;
            offset_q  <= camera_offset;
            mode_q    <= mode;
            issue_cnt <= '0;
            if (num_points != '0) begin
               zbt0_read_addr <= base_addr;
            end
         end else if (issue_fire) begin
            issue_cnt      <= issue_cnt + NUM_POINTS_W'(1);
            zbt0_read_addr <= zbt0_read_addr + 19'd1;  // wraps modulo 2^19
         end
      end
   end

   assign fifo_push = rd_vld_sr[ZBT_LATENCY-1];

   point_fifo #(
      .WIDTH (PT_WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (zbt0_read_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_dat),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (unused_fifo_full)
   );

   assign unused_bits = ^{fifo_dat.rsvd, fifo_dat.z[1:0]};

   // ---------------- pan, clip, shade ----------------
   always_comb begin
      x_sum   = {1'b0, fifo_dat.x} + (11'(offset_q) << OFFSET_SHIFT);
      x_clip  = (x_sum >= X_LIM);
      y_clip  = ({1'b0, fifo_dat.y} >= Y_LIM);
      pt_keep = !(x_clip || y_clip) || (mode_q == MODE_CLAMP);
      x_nxt   = x_sum[9:0];
      y_nxt   = fifo_dat.y;
      if (mode_q == MODE_CLAMP) begin
         if (x_clip) x_nxt = X_MAX;
         if (y_clip) y_nxt = Y_MAX;
      end
      case (mode_q)
         MODE_INVERT: pix_nxt = ~fifo_dat.z[9:2];
         MODE_WHITE:  pix_nxt = 8'hFF;
         default:     pix_nxt = fifo_dat.z[9:2];
      endcase
   end

   // Dropped points are still popped; they just never load the output register.
   assign out_free = !pt_valid || pt_ready;
   assign fifo_pop = !fifo_empty && out_free;

   always_ff @(posedge clk) begin
      if (reset) begin
         pt_valid <= 1'b0;
         x        <= '0;
         y        <= '0;
         pixel    <= '0;
      end else if (fifo_pop && pt_keep) begin
         pt_valid <= 1'b1;
         x        <= x_nxt;
         y        <= y_nxt;
         pixel    <= pix_nxt;
      end else if (pt_ready) begin
         pt_valid <= 1'b0;
      end
   end

endmodule

// File: doc/point_renderer.md
POINT_RENDERER -- requirements
Module: point_renderer

Interface
REQ-001 Parameter NUM_POINTS_W, default 19: width of point count and address.
REQ-002 Parameter ZBT_LATENCY, default 2: cycles from zbt0_read_addr to valid zbt0_read_data.
REQ-003 Parameter X_LIMIT, default 1024; Y_LIMIT, default 768: exclusive screen bounds.
REQ-004 Parameter OFFSET_SHIFT, default 2: left shift applied to camera_offset.
REQ-005 Ports, in order: clk in 1 system clock; reset in 1 reset.
REQ-006 start in 1 one-cycle pulse begins a frame; base_addr in 19 first point address; num_points in NUM_POINTS_W point count.
REQ-007 camera_offset in 6 horizontal pan; mode in 2 pixel/clip mode; zbt0_read_data in 36 packed point {6'x, x[29:20], y[19:10], z[9:0]}.
REQ-008 zbt0_read_addr out 19; pt_valid out 1; pt_ready in 1; x out 10; y out 10; pixel out 8; busy out 1; done out 1.
REQ-009 Design has one clock, clk; reset is synchronous, active-high.

Function
REQ-010 FSM states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on start when num_points!=0.
REQ-011 start with num_points==0 SHALL go IDLE->DONE, issuing no reads.
REQ-012 start while busy SHALL be ignored.
REQ-013 On accepted start: base_addr, num_points, camera_offset, mode latched; later changes have no effect until next frame.
REQ-014 ISSUE: one read per cycle at base_addr+i, i=0..num_points-1, only when outstanding reads + buffered words < FIFO depth (ZBT_LATENCY+2).
REQ-015 Address SHALL wrap modulo 2^19.
REQ-016 Returned words SHALL enter the FIFO exactly ZBT_LATENCY cycles after issue, tracked by a valid shift register; no word lost under any pt_ready pattern.
REQ-017 ISSUE->DRAIN after last read issued; DRAIN->DONE when no reads outstanding, FIFO empty, output register empty.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE.
REQ-019 busy=1 in ISSUE and DRAIN only.
REQ-020 Output is valid/ready: transfer when pt_valid&&pt_ready; x,y,pixel stable while pt_valid&&!pt_ready.
REQ-021 Output register latency: first point SHALL reach pt_valid no earlier than ZBT_LATENCY+2 cycles after start.
REQ-022 x_sum = zero-extended data[29:20] + (camera_offset<<OFFSET_SHIFT), 11 bits; x = x_sum[9:0].
REQ-023 Point clipped when x_sum>=X_LIMIT or data[19:10]>=Y_LIMIT.
REQ-024 mode 0: pixel=z[9:2], clipped points dropped.
REQ-025 mode 1: pixel=~z[9:2], clipped points dropped.
REQ-026 mode 2: pixel=8'hFF, clipped points dropped.
REQ-027 mode 3: pixel=z[9:2]; clipped points output with x,y saturated to X_LIMIT-1, Y_LIMIT-1.
REQ-028 Dropped points consume FIFO slot but produce no pt_valid; frame completes normally.
REQ-029 Points SHALL be emitted in address order.

Reset
REQ-030 reset SHALL force IDLE, pt_valid=0, busy=0, done=0, x=0, y=0, pixel=0, zbt0_read_addr=0.
REQ-031 reset mid-frame SHALL discard outstanding reads and FIFO contents; returning data ignored.
REQ-032 reset has priority over start in the same cycle.

Structure
REQ-033 Shared package: FSM state encoding, mode encodings, point field bit positions.
REQ-034 Sub-module point_fifo: synchronous FIFO, parametrised width/depth, count output.

Verification
REQ-035 num_points=4, base_addr=0x10, offset=0, mode 0, pt_ready=1: reads 0x10..0x13, four points, x/y equal to memory fields, pixel=z[9:2], one done pulse.
REQ-036 offset=6'd63, stored x=700: x_sum=952, output x=952; stored x=800: x_sum=1052, dropped in mode 0; mode 3 emits x=1023.
REQ-037 num_points=16, pt_ready toggled randomly 30% high: all 16 points emitted in order, no duplicates, outputs stable while stalled.
REQ-038 base_addr=0x7FFFE, num_points=4: addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
REQ-039 num_points=0: done pulses cycle after start, no reads, pt_valid stays 0.
REQ-040 reset asserted mid-frame with pt_ready=0: next cycle pt_valid=0, busy=0; new start produces only new-frame points.
